// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: periodic ADC scan controller that sits in front of a
// 16-bit SPI master. Each sample period it sends one command per channel,
// captures the returned word, tags it with the channel, and queues it in a
// 4-entry first-word-fall-through FIFO toward the packetiser.
module adc_spi_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned NUM_CH        = 4,
    parameter logic [15:0] CMD_TEMPLATE  = 16'h8300,
    parameter int unsigned CH_SHIFT      = 10,
    parameter int unsigned SETTLE        = 4,
    parameter int unsigned CS_GAP        = 4,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        SYS_CLK,
    input  logic        RST_n,
    input  logic        EN,
    output logic        SPI_ENA,
    output logic [15:0] SPI_DATA_MOSI,
    input  logic        SPI_FIN,
    input  logic [15:0] SPI_DATA_MISO,
    output logic [15:0] SAMPLE_DATA,
    output logic [2:0]  SAMPLE_CH,
    output logic        SAMPLE_VALID,
    input  logic        SAMPLE_READY,
    output logic        BUSY,
    output logic        OVERFLOW,
    output logic        OVERRUN,
    output logic        TIMEOUT_ERR
);

    localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [15:0]   GAP_LAST     = 16'(CS_GAP - 1);
    localparam logic [15:0]   SETTLE_LAST  = 16'(SETTLE - 1);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]    CH_LAST      = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_SETTLE,
        S_NEXT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  ch, ch_nxt;
    logic [15:0] mosi_nxt;
    logic [PW-1:0] period_cnt;
    logic        tick;
    logic        push;
    logic        set_timeout;
    logic        set_overrun;

    logic [18:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;

    function automatic logic [15:0] cmd_for(input logic [2:0] c);
        return CMD_TEMPLATE | (16'(c) << CH_SHIFT);
    endfunction

    // The counter sits at zero while disabled, so the first enabled cycle
    // and every wrap both present count zero, which is exactly the tick.
    assign tick = EN && (period_cnt == '0);

    // Free-running sample period counter, parked at zero while disabled.
    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            period_cnt <= '0;
        end else if (!EN || period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Sequencer state, step timer, channel index and the held command word.
    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            ch            <= '0;
            SPI_DATA_MOSI <= '0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            ch            <= ch_nxt;
            SPI_DATA_MOSI <= mosi_nxt;
        end
    end

    // Next-state decode: gap before each frame, bounded wait for FIN,
    // settle hold while MISO catches up, then advance or return to idle.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 16'd1;
        ch_nxt      = ch;
        mosi_nxt    = SPI_DATA_MOSI;
        push        = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (tick) begin
                    state_nxt = S_LOAD;
                    ch_nxt    = '0;
                    mosi_nxt  = cmd_for(3'd0);
                end
            end
            S_LOAD: begin
                if (timer == GAP_LAST) begin
                    state_nxt = S_XFER;
                    timer_nxt = '0;
                end
            end
            S_XFER: begin
                if (SPI_FIN) begin
                    state_nxt = S_SETTLE;
                    timer_nxt = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_NEXT;
                    timer_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    push      = 1'b1;
                    state_nxt = S_NEXT;
                    timer_nxt = '0;
                end
            end
            S_NEXT: begin
                timer_nxt = '0;
                if (!EN || ch == CH_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_LOAD;
                    ch_nxt    = ch + 3'd1;
                    mosi_nxt  = cmd_for(ch + 3'd1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // ENA is decoded straight from the state register so an asynchronous
    // reset drops it without waiting for a clock edge.
    assign SPI_ENA     = (state == S_XFER) || (state == S_SETTLE);
    assign BUSY        = (state != S_IDLE);
    assign set_overrun = tick && (state != S_IDLE);

    assign SAMPLE_VALID = (fifo_count != 3'd0);
    assign fifo_full    = (fifo_count == 3'd4);
    assign pop          = SAMPLE_VALID && SAMPLE_READY;
    assign push_ok      = push && (!fifo_full || pop);
    assign {SAMPLE_CH, SAMPLE_DATA} = fifo_mem[rd_ptr];

    // Result FIFO: a full FIFO still accepts a push when the head leaves
    // in the same cycle; an empty FIFO never bypasses its storage.
    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {ch, SPI_DATA_MISO};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky error flags, held clear for as long as the scan is disabled.
    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            OVERFLOW    <= 1'b0;
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else if (!EN) begin
            OVERFLOW    <= 1'b0;
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                OVERFLOW <= 1'b1;
            end
            if (set_overrun) begin
                OVERRUN <= 1'b1;
            end
            if (set_timeout) begin
                TIMEOUT_ERR <= 1'b1;
            end
        end
    end

endmodule
